// File: rtl/frame_pkg.sv
// frame_pkg
// Shared definitions for the frame packer slice.
//   fp_state_t  : input-side framing states (start of frame, passing, dropping)
//   FP_SOF_BIT  : position of the start-of-frame flag in a FIFO word
//   FP_EOF_BIT  : position of the end-of-frame flag in a FIFO word
//   FP_FLAG_W   : number of flag bits below the data field
// FIFO word layout is {data, eof, sof}.
package frame_pkg;

  typedef enum logic [1:0] {
    S_SOF  = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } fp_state_t;

  localparam int FP_SOF_BIT = 0;
  localparam int FP_EOF_BIT = 1;
  localparam int FP_FLAG_W  = 2;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock show-ahead FIFO: the head word is visible on rd_data whenever
// the FIFO is non-empty, and a read simply advances past it.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data: push a word (ignored when full)
//   rd_en        : pop the head word (ignored when empty)
//   rd_data      : head word, forced to zero while empty
//   level        : occupancy, 0..DEPTH
//   empty, full  : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == LVL_FULL);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign level = count;

  // Explicit wrap keeps the pointers correct for non-power-of-two depths.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge i_clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/frame_packer.sv
// frame_packer
// Groups an unthrottled sample stream into fixed-length frames, tags the first
// and last sample of each frame and buffers whole frames in a FIFO that is
// drained over a valid/ready interface. A frame is admitted only if the FIFO
// has room for all of it at its first sample; otherwise the whole frame is
// dropped, so the consumer only ever sees complete frames.
// Ports:
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_init               : realign; the next accepted sample starts a frame
//   i_data, i_dv         : input sample and its valid (no backpressure)
//   o_data, o_sof, o_eof : FIFO head sample and its frame flags
//   o_dv, i_ready        : head valid / consumer ready
//   o_level              : FIFO occupancy
//   o_frames             : frames whose eof was transferred (wraps)
//   o_drop_cnt           : dropped frames (saturates)
//   o_err                : sticky realign-mid-frame error
module frame_packer
  import frame_pkg::*;
#(
  parameter int DATA_W     = 3,
  parameter int FRAME_LEN  = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_dv,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_dv,
  input  logic              i_ready,
  output logic [LVL_W-1:0]  o_level,
  output logic [15:0]       o_frames,
  output logic [15:0]       o_drop_cnt,
  output logic              o_err
);

  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int WORD_W = DATA_W + FP_FLAG_W;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [LVL_W-1:0] ADMIT_MAX = LVL_W'(FIFO_DEPTH - FRAME_LEN);

  fp_state_t         state;
  fp_state_t         state_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;

  logic              admit;
  logic              wr_req;
  logic              wr_sof;
  logic              wr_eof;
  logic              drop_frame;
  logic              err_set;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic              fifo_empty;
  logic              fifo_full;
  logic              xfer;

  // Admission looks at the registered level only; a same-cycle read is
  // ignored, which can only make the decision more conservative.
  assign admit = (o_level <= ADMIT_MAX);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_SOF;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic; i_init overrides any sample in the same cycle.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (i_init) begin
      state_next = S_SOF;
      idx_next   = '0;
    end else if (i_dv) begin
      case (state)
        S_SOF: begin
          idx_next   = IDX_ONE;
          state_next = admit ? S_PASS : S_DROP;
        end
        S_PASS, S_DROP: begin
          if (idx == IDX_LAST) begin
            idx_next   = '0;
            state_next = S_SOF;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
        default: begin
          state_next = S_SOF;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Output logic: FIFO write request, flags and drop/error pulses.
  always_comb begin
    wr_req     = 1'b0;
    wr_sof     = 1'b0;
    wr_eof     = 1'b0;
    drop_frame = 1'b0;
    err_set    = i_init && (state == S_PASS) && (idx != '0);
    if (!i_init && i_dv) begin
      case (state)
        S_SOF: begin
          if (admit) begin
            wr_req = 1'b1;
            wr_sof = 1'b1;
          end else begin
            drop_frame = 1'b1;
          end
        end
        S_PASS: begin
          wr_req = 1'b1;
          wr_eof = (idx == IDX_LAST);
        end
        default: begin
          wr_req = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_word             = '0;
    wr_word[WORD_W-1:FP_FLAG_W] = i_data;
    wr_word[FP_SOF_BIT] = wr_sof;
    wr_word[FP_EOF_BIT] = wr_eof;
  end

  // The full guard is defensive only; admission makes a full write impossible.
  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_en   (wr_req & ~fifo_full),
    .wr_data (wr_word),
    .rd_en   (i_ready),
    .rd_data (rd_word),
    .level   (o_level),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign o_data = rd_word[WORD_W-1:FP_FLAG_W];
  assign o_sof  = rd_word[FP_SOF_BIT];
  assign o_eof  = rd_word[FP_EOF_BIT];
  assign o_dv   = ~fifo_empty;
  assign xfer   = o_dv & i_ready;

  // Status counters: frames wrap, drops saturate, error is sticky.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frames   <= '0;
      o_drop_cnt <= '0;
      o_err      <= 1'b0;
    end else begin
      if (xfer && o_eof) begin
        o_frames <= o_frames + 16'd1;
      end
      if (drop_frame && (o_drop_cnt != 16'hFFFF)) begin
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end
      if (err_set) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer
// Directed bench for frame_packer (DATA_W=3, FRAME_LEN=8, FIFO_DEPTH=16).
// A queue-based model of whole-frame admission tracks the expected FIFO
// contents and counters; every negedge the DUT outputs are compared with it.
// Directed scenarios add hand-computed literal checks.
module tb_frame_packer;

  localparam int DATA_W     = 3;
  localparam int FRAME_LEN  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eof;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              init;
  logic              dv;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic [DATA_W-1:0] o_data;
  logic              o_sof;
  logic              o_eof;
  logic              o_dv;
  logic [LVL_W-1:0]  o_level;
  logic [15:0]       o_frames;
  logic [15:0]       o_drop_cnt;
  logic              o_err;

  int vectors     = 0;
  int miscompares = 0;

  exp_t        q[$];
  int          pos;
  bit          keep;
  int          pre_size;
  logic [15:0] m_frames;
  logic [15:0] m_drop;
  logic        m_err;

  frame_packer #(
    .DATA_W     (DATA_W),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_init     (init),
    .i_data     (data),
    .i_dv       (dv),
    .o_data     (o_data),
    .o_sof      (o_sof),
    .o_eof      (o_eof),
    .o_dv       (o_dv),
    .i_ready    (ready),
    .o_level    (o_level),
    .o_frames   (o_frames),
    .o_drop_cnt (o_drop_cnt),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return at the following negedge.
  task automatic applyStimulus(input logic r, input logic in, input logic v,
                               input logic [DATA_W-1:0] d, input logic rd);
    rst   = r;
    init  = in;
    dv    = v;
    data  = d;
    ready = rd;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input logic rd);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, '0, rd);
  endtask

  // Model: frame position counter plus keep/drop decision made at each frame
  // start from the occupancy seen before this cycle's read.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      pos      = 0;
      keep     = 1'b0;
      m_frames = '0;
      m_drop   = '0;
      m_err    = 1'b0;
    end else begin
      pre_size = q.size();
      if (ready && pre_size > 0) begin
        if (q[0].eof) m_frames = m_frames + 16'd1;
        void'(q.pop_front());
      end
      if (init) begin
        if (keep && pos != 0) m_err = 1'b1;
        pos = 0;
      end else if (dv) begin
        if (pos == 0) begin
          keep = (pre_size <= FIFO_DEPTH - FRAME_LEN);
          if (!keep && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        if (keep) q.push_back('{data: data, sof: (pos == 0), eof: (pos == FRAME_LEN - 1)});
        pos = (pos + 1) % FRAME_LEN;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    checkOutput("model_dv", o_dv, (q.size() > 0));
    if (q.size() > 0) begin
      checkOutput("model_data", o_data, q[0].data);
      checkOutput("model_sof", o_sof, q[0].sof);
      checkOutput("model_eof", o_eof, q[0].eof);
    end else begin
      checkOutput("empty_data", o_data, 0);
      checkOutput("empty_sof", o_sof, 0);
      checkOutput("empty_eof", o_eof, 0);
    end
    checkOutput("model_level", o_level, q.size());
    checkOutput("model_frames", o_frames, m_frames);
    checkOutput("model_drop", o_drop_cnt, m_drop);
    checkOutput("model_err", o_err, m_err);
  end

  // A write request must never meet a full FIFO.
  always @(negedge clk) begin
    #4;
    if (dut.wr_req) checkOutput("write_while_full", dut.fifo_full, 0);
  end

  int n_xfer;
  int n_sof;
  int n_eof;
  logic [DATA_W-1:0] init_exp_data [4];
  logic              init_exp_sof  [4];

  initial begin
    // Reset held two cycles with samples present: nothing may be written.
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd5, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd5, 1'b1);
    checkOutput("reset_dv", o_dv, 0);
    checkOutput("reset_level", o_level, 0);
    checkOutput("reset_frames", o_frames, 0);
    checkOutput("reset_drop", o_drop_cnt, 0);
    checkOutput("reset_err", o_err, 0);

    // Streaming with ready held: head is the sample just written.
    for (int i = 0; i < FRAME_LEN; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 3'(i), 1'b1);
      checkOutput("stream_head", o_data, i);
      checkOutput("stream_level_le1", (o_level <= 1), 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("stream_frames_1", o_frames, 1);
    checkOutput("stream_drained", o_dv, 0);
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 3'(i % FRAME_LEN), 1'b1);
      checkOutput("stream_level_le1", (o_level <= 1), 1);
    end
    idleCycles(2, 1'b1);
    checkOutput("stream_frames_3", o_frames, 3);

    // Overflow: 24 samples stalled, third frame dropped.
    for (int i = 0; i < 3 * FRAME_LEN; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 3'(i % FRAME_LEN), 1'b0);
    checkOutput("ovf_level", o_level, 16);
    checkOutput("ovf_drop", o_drop_cnt, 1);
    n_xfer = 0;
    n_sof  = 0;
    n_eof  = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_dv) begin
        n_xfer++;
        if (o_sof) n_sof++;
        if (o_eof) n_eof++;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkOutput("ovf_xfers", n_xfer, 16);
    checkOutput("ovf_sofs", n_sof, 2);
    checkOutput("ovf_eofs", n_eof, 2);
    checkOutput("ovf_frames", o_frames, 5);

    // Admission boundary: level 8 admits, level 9 drops.
    for (int i = 0; i < FRAME_LEN; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 3'(i), 1'b0);
    checkOutput("adm_level_8", o_level, 8);
    for (int i = 0; i < FRAME_LEN; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 3'(7 - i), 1'b0);
    checkOutput("adm_level_16", o_level, 16);
    checkOutput("adm_drop_1", o_drop_cnt, 1);
    idleCycles(7, 1'b1);
    checkOutput("adm_level_9", o_level, 9);
    for (int i = 0; i < FRAME_LEN; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 3'(i), 1'b0);
    checkOutput("adm_drop_2", o_drop_cnt, 2);
    checkOutput("adm_level_9_kept", o_level, 9);
    idleCycles(12, 1'b1);
    checkOutput("adm_frames", o_frames, 7);
    checkOutput("adm_empty", o_level, 0);

    // Realign after three samples of a passing frame.
    for (int i = 1; i <= 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 3'(i), 1'b0);
    checkOutput("init_err_before", o_err, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd6, 1'b0);
    checkOutput("init_err_set", o_err, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
    checkOutput("init_level", o_level, 4);
    init_exp_data = '{3'd1, 3'd2, 3'd3, 3'd4};
    init_exp_sof  = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      checkOutput("init_seq_data", o_data, init_exp_data[k]);
      checkOutput("init_seq_sof", o_sof, init_exp_sof[k]);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    end
    checkOutput("init_err_sticky", o_err, 1);

    // Reset in the middle of a frame with five samples buffered.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 3'(i), 1'b0);
    checkOutput("rstmid_level_5", o_level, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd7, 1'b0);
    checkOutput("rstmid_dv", o_dv, 0);
    checkOutput("rstmid_level", o_level, 0);
    checkOutput("rstmid_err", o_err, 0);
    checkOutput("rstmid_drop", o_drop_cnt, 0);
    checkOutput("rstmid_frames", o_frames, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    checkOutput("rstmid_sof", o_sof, 1);
    checkOutput("rstmid_data", o_data, 3);
    idleCycles(3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_packer.md
# frame_packer

Frame-aligning stream buffer placed directly downstream of the sample counter/source stage. It takes the unthrottled `i_data`/`i_dv` sample stream, groups samples into fixed-length frames and tags the first and last sample of each frame. Frames are buffered in a FIFO and emitted on a valid/ready interface. Admission is frame-level: a frame is either fully stored or fully dropped, so the consumer only ever sees whole frames.

## Interface
- `DATA_W`, default 3: sample width; matches counter output for MAX_VAL=8.
- `FRAME_LEN`, default 8: samples per frame; must be ≥2.
- `FIFO_DEPTH`, default 16: FIFO entries; must be ≥FRAME_LEN.
- `i_clk`  in  1  clock; single clock domain.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_init`  in  1  realign: the next accepted sample starts a new frame.
- `i_data`  in  DATA_W  input sample.
- `i_dv`  in  1  input sample valid; there is no backpressure toward upstream.
- `o_data`  out  DATA_W  FIFO head sample.
- `o_sof`  out  1  head sample is the first sample of a frame.
- `o_eof`  out  1  head sample is the last sample of a frame.
- `o_dv`  out  1  FIFO not empty.
- `i_ready`  in  1  consumer accepts the head; transfer = `o_dv & i_ready`.
- `o_level`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- `o_frames`  out  16  count of frames whose eof was transferred; wraps.
- `o_drop_cnt`  out  16  count of dropped frames; saturates at 16'hFFFF.
- `o_err`  out  1  sticky; set by `i_init` arriving mid-frame in S_PASS.

## Operation
- Input FSM, states S_SOF, S_PASS, S_DROP, plus frame index `idx` (0..FRAME_LEN-1).
- S_SOF, on `i_dv`:
  - If `o_level <= FIFO_DEPTH-FRAME_LEN`: write {sof=1, eof=0, data}, set idx=1, go to S_PASS.
  - Otherwise: discard the sample, increment `o_drop_cnt`, set idx=1, go to S_DROP.
- S_PASS, on `i_dv`: write {sof=0, eof=(idx==FRAME_LEN-1), data}.
- S_DROP, on `i_dv`: discard the sample.
- In S_PASS and S_DROP, on a sample with idx==FRAME_LEN-1: set idx=0, go to S_SOF. Otherwise increment idx.
- Admission uses the registered `o_level`, which ignores a read in the same cycle. This is conservative. An admitted frame can never overflow, because this block is the only writer.
- `i_init` has priority over `i_dv` in the same cycle. It forces idx=0 and S_SOF, and the sample in that cycle is ignored.
  - If the state was S_PASS with idx>0, `o_err` is set. The partial frame stays in the FIFO without an eof.
  - `i_init` in S_SOF or S_DROP has no other effect.
- Output side: show-ahead FIFO. `o_data`/`o_sof`/`o_eof` are valid whenever `o_dv=1`. They must hold stable while `o_dv & !i_ready`.
- A write and a read in the same cycle leave `o_level` unchanged.
- `o_frames` increments on a transfer with `o_eof=1`.

## Timing
- Reset values: `o_dv=0`, `o_level=0`, `o_frames=0`, `o_drop_cnt=0`, `o_err=0`, state S_SOF, idx=0. `o_data`/`o_sof`/`o_eof` read as 0 while empty.
- Latency: a sample written at edge k gives `o_dv=1` with that sample at the head right after edge k. With `i_ready=1` held, output trails input by exactly 1 cycle.
- Throughput: 1 sample per cycle, sustained.
- Synchronous reset mid-operation: FIFO is emptied, all counters and the FSM return to reset values on that edge, and any in-flight frame is lost.
- FIFO full (only reachable via an admitted frame plus stall): unreachable for writes by construction. Verification must assert "write while full" never fires.
- Empty read: `i_ready` while `o_dv=0` has no effect.

## Structure
- Package `frame_pkg` holds:
  - The state enum `fp_state_t` {S_SOF, S_PASS, S_DROP}.
  - Constants `FP_SOF_BIT=0`, `FP_EOF_BIT=1`, giving the flag positions in the FIFO word. The FIFO word is {data, eof, sof}, width DATA_W+2.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): show-ahead, single clock, synchronous active-high reset, outputs level/empty/full.
- `frame_packer` contains the FSM, the counters and the FIFO instance.

## Test plan
All tests use DATA_W=3, FRAME_LEN=8, FIFO_DEPTH=16.
- **Reset:** hold `i_rst` 2 cycles with `i_dv=1` → all outputs zero and no writes.
- **Streaming:** `i_dv=1` continuously, data 0..7 repeating, `i_ready=1` → output equals input delayed 1 cycle; `o_sof` on 0, `o_eof` on 7; `o_frames=1` after the 8th transfer; `o_level` ≤1 throughout.
- **Overflow:** `i_ready=0`, feed 24 samples → frames 1–2 stored (`o_level=16`), frame 3 dropped, `o_drop_cnt=1`. Then `i_ready=1` → exactly 16 transfers, 2 sof/eof pairs, `o_frames=2`.
- **Admission boundary:** at a frame start, `o_level=8` → frame admitted; at `o_level=9` → frame dropped.
- **Mid-frame init:** `i_init` after 3 PASS samples → `o_err=1`; the next sample has `o_sof=1`; the `i_init`-cycle sample is absent from the output.
- **Reset mid-frame:** reset with `o_level=5` → `o_dv=0` and `o_level=0` after the edge; the next sample is tagged sof.
